cache_sdpb: RTL and testbench

Datapath primitive pair for the frame uploader: a 16-entry × 16-bit simple dual-port cache with a 32-bit read port, and a registered address adder. The uploader fills the cache from the pixel queue one 16-bit pixel at a time and drains it as 32-bit words to memory. The adder advances the memory write address by the number of pixels just written. Both functions share one clock and one reset and have no internal interaction.

---
 rtl/cache_sdpb_pkg.sv | 19 +
 rtl/cache_sdpb_if.sv | 28 ++
 rtl/alu54_adder.sv | 31 +++
 rtl/cache_sdpb.sv | 52 +++++
 tb/tb_cache_sdpb.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cache_sdpb_pkg.sv
// Shared widths and payload types for the frame-uploader cache and address adder.
package cache_sdpb_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned RD_W      = 32;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned RD_ADDR_W = 3;
  localparam int unsigned A_W       = 21;
  localparam int unsigned B_W       = 11;
  localparam int unsigned SUM_W     = 22;
  localparam int unsigned CASO_W    = 55;

  // 32-bit read word: even entry in the low half
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } rd_word_t;

endpackage

// File: rtl/cache_sdpb_if.sv
// Cache write/read ports and adder operands/results for cache_sdpb.
interface cache_sdpb_if;
  import cache_sdpb_pkg::*;

  logic                 cea;
  logic [ADDR_W-1:0]    ada;
  logic [DATA_W-1:0]    din;
  logic                 ceb;
  logic [RD_ADDR_W-1:0] adb;
  logic                 oce;
  logic [RD_W-1:0]      dout;
  logic                 ce;
  logic [A_W-1:0]       a;
  logic [B_W-1:0]       b;
  logic [SUM_W-1:0]     sum;
  logic [CASO_W-1:0]    caso;

  modport master (
    output cea, ada, din, ceb, adb, oce, ce, a, b,
    input  dout, sum, caso
  );

  modport slave (
    input  cea, ada, din, ceb, adb, oce, ce, a, b,
    output dout, sum, caso
  );

endinterface

// File: rtl/alu54_adder.sv
// Registered 21+11 bit unsigned address adder with zero-padded cascade output.
module alu54_adder
  import cache_sdpb_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_ce,
  input  logic [A_W-1:0]    i_a,
  input  logic [B_W-1:0]    i_b,
  output logic [SUM_W-1:0]  o_sum,
  output logic [CASO_W-1:0] o_caso
);

  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] w_sum_next;

  // Carry lands in the top bit, so the 22-bit result never wraps
  assign w_sum_next = SUM_W'(i_a) + SUM_W'(i_b);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (i_ce) begin
      r_sum <= w_sum_next;
    end
  end

  assign o_sum  = r_sum;
  assign o_caso = {(CASO_W - SUM_W)'(0), r_sum};

endmodule

// File: rtl/cache_sdpb.sv
// 16x16 simple dual-port cache with a 32-bit read-first read port, plus the address adder.
module cache_sdpb
  import cache_sdpb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  cache_sdpb_if.slave  bus
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  rd_word_t          r_dout;
  logic [ADDR_W-1:0] w_rd_lo;
  logic [ADDR_W-1:0] w_rd_hi;
  logic              w_unused_oce;

  // The uploader only uses the single-register output mode
  assign w_unused_oce = bus.oce;

  assign w_rd_lo = {bus.adb, 1'b0};
  assign w_rd_hi = {bus.adb, 1'b1};

  // Storage survives reset; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (reset_n && bus.cea) begin
      r_mem[bus.ada] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= '0;
    end else if (bus.ceb) begin
      r_dout.hi <= r_mem[w_rd_hi];
      r_dout.lo <= r_mem[w_rd_lo];
    end
  end

  assign bus.dout = r_dout;

  alu54_adder u_adder (
    .clk     (clk),
    .reset_n (reset_n),
    .i_ce    (bus.ce),
    .i_a     (bus.a),
    .i_b     (bus.b),
    .o_sum   (bus.sum),
    .o_caso  (bus.caso)
  );

endmodule

// File: tb/tb_cache_sdpb.sv
// Self-checking bench for cache_sdpb against an array/arithmetic reference model.
module tb_cache_sdpb;
  import cache_sdpb_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  logic [15:0] m [16];
  logic [31:0] exp_dout;
  logic [21:0] exp_sum;

  cache_sdpb_if bus ();

  cache_sdpb #(.DEPTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply current inputs at the next rising edge, updating the model, then settle.
  task automatic cycle();
    if (reset_n) begin
      if (bus.ceb) exp_dout = {m[2*int'(bus.adb)+1], m[2*int'(bus.adb)]};
      if (bus.cea) m[bus.ada] = bus.din;
      if (bus.ce)  exp_sum = 22'(int'(bus.a) + int'(bus.b));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cea = 1'b0; bus.ada = '0; bus.din = '0;
    bus.ceb = 1'b0; bus.adb = '0; bus.oce = 1'b0;
    bus.ce  = 1'b0; bus.a   = '0; bus.b   = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    bus.ceb = 1'b1; bus.ce = 1'b1; bus.a = 21'h1234; bus.b = 11'h7;
    for (int i = 0; i < 16; i++) m[i] = '0;
    exp_dout = '0; exp_sum = '0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bus.dout !== 32'd0) begin errors++; $display("FAIL reset_dout got %h exp 0", bus.dout); end
    checks++;
    if (bus.sum !== 22'd0) begin errors++; $display("FAIL reset_sum got %h exp 0", bus.sum); end
    checks++;
    if (bus.caso !== 55'd0) begin errors++; $display("FAIL reset_caso got %h exp 0", bus.caso); end
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_readback();
    logic [31:0] want;
    for (int i = 0; i < 16; i++) begin
      bus.cea = 1'b1; bus.ada = 4'(i); bus.din = 16'h1000 + 16'(i);
      cycle();
    end
    bus.cea = 1'b0;
    for (int j = 0; j < 8; j++) begin
      bus.ceb = 1'b1; bus.adb = 3'(j);
      cycle();
      want = {16'h1001 + 16'(2*j), 16'h1000 + 16'(2*j)};
      checks++;
      if (bus.dout !== want || bus.dout !== exp_dout) begin
        errors++; $display("FAIL fill_read adb=%0d got %h exp %h", j, bus.dout, want);
      end
    end
    bus.ceb = 1'b0;
  endtask

  task automatic test_hold();
    for (int k = 0; k < 4; k++) begin
      bus.ceb = 1'b0; bus.adb = 3'(k + 1);
      cycle();
      checks++;
      if (bus.dout !== 32'h100F_100E) begin
        errors++; $display("FAIL hold_dout got %h exp 100f100e", bus.dout);
      end
    end
  endtask

  task automatic test_read_first();
    bus.cea = 1'b1; bus.ada = 4'd4; bus.din = 16'hAAAA;
    cycle();
    bus.cea = 1'b1; bus.ada = 4'd4; bus.din = 16'h5555;
    bus.ceb = 1'b1; bus.adb = 3'd2;
    cycle();
    checks++;
    if (bus.dout !== 32'h1005_AAAA) begin
      errors++; $display("FAIL read_first_old got %h exp 1005aaaa", bus.dout);
    end
    bus.cea = 1'b0;
    cycle();
    checks++;
    if (bus.dout !== 32'h1005_5555) begin
      errors++; $display("FAIL read_first_new got %h exp 10055555", bus.dout);
    end
    bus.ceb = 1'b0;
  endtask

  task automatic test_adder();
    bus.ce = 1'b1; bus.a = 21'h1F_FFFF; bus.b = 11'd16;
    cycle();
    checks++;
    if (bus.sum !== 22'h20_000F) begin
      errors++; $display("FAIL adder_carry_sum got %h exp 20000f", bus.sum);
    end
    checks++;
    if (bus.caso !== 55'h20_000F) begin
      errors++; $display("FAIL adder_carry_caso got %h exp 20000f", bus.caso);
    end
    bus.ce = 1'b0; bus.a = 21'h5; bus.b = 11'h7;
    repeat (2) cycle();
    checks++;
    if (bus.sum !== 22'h20_000F || bus.caso !== 55'h20_000F) begin
      errors++; $display("FAIL adder_hold got %h exp 20000f", bus.sum);
    end
  endtask

  task automatic test_async_reset();
    bus.ceb = 1'b1; bus.adb = 3'd0;
    bus.ce = 1'b1; bus.a = 21'h100; bus.b = 11'h1;
    cycle();
    checks++;
    if (bus.dout !== 32'h1001_1000 || bus.sum !== 22'h101) begin
      errors++; $display("FAIL pre_reset got dout %h sum %h exp 10011000 101", bus.dout, bus.sum);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.dout !== 32'd0 || bus.sum !== 22'd0 || bus.caso !== 55'd0) begin
      errors++; $display("FAIL async_clear got dout %h sum %h caso %h exp 0", bus.dout, bus.sum, bus.caso);
    end
    bus.cea = 1'b1; bus.ada = 4'd0; bus.din = 16'hFFFF;
    @(posedge clk); #1;
    checks++;
    if (bus.dout !== 32'd0 || bus.sum !== 22'd0) begin
      errors++; $display("FAIL reset_hold got dout %h sum %h exp 0", bus.dout, bus.sum);
    end
    reset_n = 1'b1;
    exp_dout = '0; exp_sum = '0;
    bus.cea = 1'b0; bus.ceb = 1'b1; bus.adb = 3'd0; bus.ce = 1'b0;
    cycle();
    checks++;
    if (bus.dout[15:0] !== 16'h1000 || bus.dout !== exp_dout) begin
      errors++; $display("FAIL mem_survives_reset got %h exp %h", bus.dout, exp_dout);
    end
    checks++;
    if (bus.sum !== 22'd0) begin
      errors++; $display("FAIL sum_after_reset got %h exp 0", bus.sum);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      bus.cea = 1'($urandom_range(0, 1));
      bus.ada = 4'($urandom);
      bus.din = 16'($urandom);
      bus.ceb = 1'($urandom_range(0, 1));
      bus.adb = 3'($urandom);
      bus.oce = 1'($urandom);
      bus.ce  = 1'($urandom_range(0, 1));
      bus.a   = (n % 16 == 0) ? 21'h1F_FFFF : 21'($urandom);
      bus.b   = (n % 16 == 0) ? 11'h7FF : 11'($urandom);
      cycle();
      checks++;
      if (bus.dout !== exp_dout) begin
        errors++; $display("FAIL rand_dout n=%0d got %h exp %h", n, bus.dout, exp_dout);
      end
      checks++;
      if (bus.sum !== exp_sum || bus.caso !== {33'd0, exp_sum}) begin
        errors++; $display("FAIL rand_sum n=%0d got %h caso %h exp %h", n, bus.sum, bus.caso, exp_sum);
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_readback();
    test_hold();
    test_read_first();
    test_adder();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
